// File: rtl/pixel_word_unpacker.sv
// Splits packed words into single pixels for the HOG core, LSB lane first,
// while tracking raster position, end-of-line/frame sideband and a frame counter.
module pixel_word_unpacker #(
  parameter int DATA_WIDTH   = 8,
  parameter int WORD_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  pixel_eol,
  output logic                  pixel_eof,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int PPW    = WORD_WIDTH / DATA_WIDTH;
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPW - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMAGE_HEIGHT - 1);

  // A word must hold whole pixels and a line must hold whole words, otherwise
  // a line or frame boundary would land in the middle of a word.
  generate
    if (WORD_WIDTH % DATA_WIDTH != 0) begin : g_bad_word_width
      $error("WORD_WIDTH must be a multiple of DATA_WIDTH");
    end
    if (IMAGE_WIDTH % PPW != 0) begin : g_bad_image_width
      $error("IMAGE_WIDTH must be a multiple of WORD_WIDTH/DATA_WIDTH");
    end
  endgenerate

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state_reg, state_next;
  logic [WORD_WIDTH-1:0] word_reg, word_next;
  logic [LANE_W-1:0]     lane_reg, lane_next;
  logic [COL_W-1:0]      col_reg;
  logic [ROW_W-1:0]      row_reg;
  logic                  frame_done_reg;
  logic [15:0]           frame_count_reg;

  logic [DATA_WIDTH-1:0] lanes [PPW];
  logic                  last_lane;
  logic                  pixel_fire;
  logic                  at_eol;
  logic                  at_eof;

  genvar gi;
  generate
    for (gi = 0; gi < PPW; gi++) begin : g_lane
      assign lanes[gi] = word_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign last_lane  = (lane_reg == LAST_LANE);
  assign pixel_fire = (state_reg == FULL) & pixel_ready;
  assign at_eol     = (col_reg == LAST_COL);
  assign at_eof     = at_eol & (row_reg == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      word_reg  <= '0;
      lane_reg  <= '0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      lane_reg  <= lane_next;
    end
  end

  // word_ready depends combinationally on pixel_ready so the last lane can be
  // refilled on the same edge it drains, giving one pixel per cycle.
  always_comb begin
    state_next  = state_reg;
    word_next   = word_reg;
    lane_next   = lane_reg;
    pixel_valid = 1'b0;
    word_ready  = 1'b0;
    case (state_reg)
      EMPTY: begin
        word_ready = 1'b1;
        if (word_valid) begin
          word_next  = word_in;
          lane_next  = '0;
          state_next = FULL;
        end
      end
      FULL: begin
        pixel_valid = 1'b1;
        word_ready  = last_lane & pixel_ready;
        if (pixel_ready) begin
          if (!last_lane) begin
            lane_next = lane_reg + 1'b1;
          end else if (word_valid) begin
            word_next = word_in;
            lane_next = '0;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg         <= '0;
      row_reg         <= '0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      frame_done_reg <= pixel_fire & at_eof;
      if (pixel_fire) begin
        if (at_eol) begin
          col_reg <= '0;
          row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
        if (at_eof) begin
          frame_count_reg <= frame_count_reg + 16'd1;
        end
      end
    end
  end

  assign pixel_out   = lanes[lane_reg];
  assign pixel_eol   = pixel_valid & at_eol;
  assign pixel_eof   = pixel_valid & at_eof;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_pixel_word_unpacker.sv
// Directed bench for pixel_word_unpacker; a 16x6 frame keeps whole-frame runs short.
module tb_pixel_word_unpacker;

  localparam int W = 16;
  localparam int H = 6;

  logic        clk;
  logic        rst_n;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        pixel_eol;
  logic        pixel_eof;
  logic        frame_done;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pix      = 0;   // position of the next pixel within its frame
  int frames   = 0;

  pixel_word_unpacker #(
    .DATA_WIDTH(8), .WORD_WIDTH(32), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_eol(pixel_eol), .pixel_eof(pixel_eof),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit eol_f(int p);
    return (p % W) == W - 1;
  endfunction

  function automatic bit eof_f(int p);
    return p == W * H - 1;
  endfunction

  function automatic logic [31:0] pack(int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic advance;
    if (pix == W * H - 1) begin
      pix = 0;
      frames++;
    end else begin
      pix++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; word_in = '0; word_valid = 1'b0; pixel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_valid got %b want 0", pixel_valid); end
    n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_word_ready got %b want 1", word_ready); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_checks++; if ({pixel_eol, pixel_eof, pixel_out} !== 10'd0) begin n_fail++; $display("FAIL reset_pixel_side got %b want 0", {pixel_eol, pixel_eof, pixel_out}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix = 0; frames = 0;
    $display("reset: checked outputs in reset");
  endtask

  task automatic test_single_word;
    logic [31:0] w;
    logic [7:0]  exp_b;
    w = 32'h44332211;
    @(posedge clk); #1;
    word_in = w; word_valid = 1'b1; pixel_ready = 1'b1;
    #1;
    n_checks++; if (word_ready !== 1'b1 || pixel_valid !== 1'b0) begin n_fail++; $display("FAIL single_load ready/valid got %b%b want 10", word_ready, pixel_valid); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      word_valid = 1'b0; word_in = 32'hDEADBEEF;
      #1;
      exp_b = w[k*8 +: 8];
      n_checks++; if (pixel_valid !== 1'b1 || pixel_out !== exp_b) begin n_fail++; $display("FAIL single_pixel k=%0d got v=%b %h want v=1 %h", k, pixel_valid, pixel_out, exp_b); end
      n_checks++; if (word_ready !== (k == 3)) begin n_fail++; $display("FAIL single_word_ready k=%0d got %b want %b", k, word_ready, k == 3); end
      n_checks++; if (pixel_eol !== eol_f(pix)) begin n_fail++; $display("FAIL single_eol k=%0d got %b want %b", k, pixel_eol, eol_f(pix)); end
      $display("single: lane %0d pixel %h", k, pixel_out);
      advance();
    end
    @(posedge clk); #2;
    n_checks++; if (pixel_valid !== 1'b0 || word_ready !== 1'b1) begin n_fail++; $display("FAIL single_drain valid/ready got %b%b want 01", pixel_valid, word_ready); end
  endtask

  task automatic test_continuous;
    @(posedge clk); #1;
    word_in = pack(0); word_valid = 1'b1; pixel_ready = 1'b1;
    #1;
    n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL cont_load word_ready got %b want 1", word_ready); end
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      word_valid = (c / 4) < 3;
      word_in = ((c / 4) < 3) ? pack(4 * (c / 4 + 1)) : 32'h0;
      #1;
      n_checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'(c)) begin n_fail++; $display("FAIL cont_pixel c=%0d got v=%b %h want v=1 %h", c, pixel_valid, pixel_out, 8'(c)); end
      n_checks++; if (word_ready !== ((c % 4) == 3)) begin n_fail++; $display("FAIL cont_word_ready c=%0d got %b want %b", c, word_ready, (c % 4) == 3); end
      n_checks++; if (pixel_eol !== eol_f(pix)) begin n_fail++; $display("FAIL cont_eol c=%0d got %b want %b", c, pixel_eol, eol_f(pix)); end
      $display("continuous: cycle %0d pixel %h word_ready %b eol %b", c, pixel_out, word_ready, pixel_eol);
      advance();
    end
    @(posedge clk); #2;
    n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL cont_drain pixel_valid got %b want 0", pixel_valid); end
  endtask

  task automatic test_stall;
    logic [7:0] exp_b [8];
    int idx, stall_left, cyc;
    logic tog, rdy;
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h55, 8'h66, 8'h77, 8'h88};
    @(posedge clk); #1;
    word_in = 32'hD4C3B2A1; word_valid = 1'b1; pixel_ready = 1'b0;
    #1;
    n_checks++; if (word_ready !== 1'b1) begin n_fail++; $display("FAIL stall_load word_ready got %b want 1", word_ready); end
    idx = 0; stall_left = 5; cyc = 0; tog = 1'b1;
    while (idx < 8 && cyc < 60) begin
      @(posedge clk); #1;
      if (idx == 3 && stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end else if (idx == 3 || idx == 7) begin
        rdy = 1'b1;
      end else begin
        rdy = tog; tog = ~tog;
      end
      word_valid = idx < 4; word_in = 32'h88776655; pixel_ready = rdy;
      #1;
      n_checks++; if (pixel_valid !== 1'b1 || pixel_out !== exp_b[idx]) begin n_fail++; $display("FAIL stall_pixel idx=%0d got v=%b %h want v=1 %h", idx, pixel_valid, pixel_out, exp_b[idx]); end
      n_checks++; if (word_ready !== ((idx % 4) == 3 && rdy)) begin n_fail++; $display("FAIL stall_word_ready idx=%0d got %b want %b", idx, word_ready, (idx % 4) == 3 && rdy); end
      n_checks++; if (pixel_eol !== eol_f(pix)) begin n_fail++; $display("FAIL stall_eol idx=%0d got %b want %b", idx, pixel_eol, eol_f(pix)); end
      $display("stall: cycle %0d ready %b pixel %h word_ready %b", cyc, rdy, pixel_out, word_ready);
      if (rdy) begin
        advance();
        idx++;
      end
      cyc++;
    end
    n_checks++; if (idx != 8) begin n_fail++; $display("FAIL stall_timeout accepted %0d want 8", idx); end
    @(posedge clk); #1;
    word_valid = 1'b0; pixel_ready = 1'b1;
    #1;
    n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain pixel_valid got %b want 0", pixel_valid); end
  endtask

  task automatic test_reset_mid_frame;
    int wsent;
    // Stream from pixel 28 until row 3 col 2, i.e. two lanes into a word.
    @(posedge clk); #1;
    word_in = pack(0); word_valid = 1'b1; pixel_ready = 1'b1; wsent = 1;
    #1;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      word_valid = 1'b1; word_in = pack(4 * wsent);
      #1;
      n_checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'(k)) begin n_fail++; $display("FAIL midrst_pixel k=%0d got v=%b %h want v=1 %h", k, pixel_valid, pixel_out, 8'(k)); end
      n_checks++; if (pixel_eol !== eol_f(pix) || frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_side k=%0d got eol=%b fd=%b want eol=%b fd=0", k, pixel_eol, frame_done, eol_f(pix)); end
      if ((k % 4) == 3) wsent++;
      advance();
    end
    @(posedge clk); #1;
    pixel_ready = 1'b0; word_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pixel_valid !== 1'b0 || word_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_async valid/ready got %b%b want 01", pixel_valid, word_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix = 0;
    #1;
    n_checks++; if (frame_done !== 1'b0 || frame_count !== 16'd0 || pixel_eol !== 1'b0) begin n_fail++; $display("FAIL midrst_release fd=%b cnt=%0d eol=%b want 0 0 0", frame_done, frame_count, pixel_eol); end
    $display("reset_mid_frame: reset applied at row 3 col 2");
    word_in = pack(100); word_valid = 1'b1; pixel_ready = 1'b1; wsent = 1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      word_valid = wsent < 4; word_in = pack(100 + 4 * wsent);
      #1;
      n_checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'(100 + k)) begin n_fail++; $display("FAIL postrst_pixel k=%0d got v=%b %h want v=1 %h", k, pixel_valid, pixel_out, 8'(100 + k)); end
      n_checks++; if (pixel_eol !== eol_f(pix) || frame_done !== 1'b0) begin n_fail++; $display("FAIL postrst_side k=%0d got eol=%b fd=%b want eol=%b fd=0", k, pixel_eol, frame_done, eol_f(pix)); end
      $display("reset_mid_frame: post-reset pixel %0d = %h eol %b", k, pixel_out, pixel_eol);
      if ((k % 4) == 3) wsent++;
      advance();
    end
  endtask

  task automatic test_full_frame;
    int wsent, total, eol_seen;
    bit fd_exp;
    // Finish the frame begun after reset, then run a whole second frame back to back.
    total = (W * H - pix) + W * H;
    eol_seen = 0; fd_exp = 1'b0;
    @(posedge clk); #1;
    word_in = pack(0); word_valid = 1'b1; pixel_ready = 1'b1; wsent = 1;
    #1;
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      word_valid = wsent < total / 4; word_in = pack(4 * wsent);
      #1;
      n_checks++; if (pixel_valid !== 1'b1 || pixel_out !== 8'(k)) begin n_fail++; $display("FAIL frame_pixel k=%0d got v=%b %h want v=1 %h", k, pixel_valid, pixel_out, 8'(k)); end
      n_checks++; if (pixel_eol !== eol_f(pix) || pixel_eof !== eof_f(pix)) begin n_fail++; $display("FAIL frame_side k=%0d pix=%0d got eol=%b eof=%b want eol=%b eof=%b", k, pix, pixel_eol, pixel_eof, eol_f(pix), eof_f(pix)); end
      n_checks++; if (frame_done !== fd_exp || frame_count !== 16'(frames)) begin n_fail++; $display("FAIL frame_status k=%0d got fd=%b cnt=%0d want fd=%b cnt=%0d", k, frame_done, frame_count, fd_exp, frames); end
      if (pixel_eol === 1'b1) eol_seen++;
      if (eol_f(pix)) $display("frame: accept k=%0d pix=%0d eol %b eof %b count %0d", k, pix, pixel_eol, pixel_eof, frame_count);
      if ((k % 4) == 3) wsent++;
      fd_exp = eof_f(pix);
      advance();
    end
    n_checks++; if (eol_seen != (total / W)) begin n_fail++; $display("FAIL frame_eol_count got %0d want %0d", eol_seen, total / W); end
    @(posedge clk); #2;
    n_checks++; if (frame_done !== 1'b1 || frame_count !== 16'd2) begin n_fail++; $display("FAIL frame_end got fd=%b cnt=%0d want fd=1 cnt=2", frame_done, frame_count); end
    @(posedge clk); #2;
    n_checks++; if (frame_done !== 1'b0 || pixel_valid !== 1'b0) begin n_fail++; $display("FAIL frame_after got fd=%b v=%b want 0 0", frame_done, pixel_valid); end
    $display("frame: done, frame_count %0d", frame_count);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_continuous();
    test_stall();
    test_reset_mid_frame();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
